// File: rtl/jt51_eg_rd_slot_cnt.sv
// jt51_slot_cnt: 32-slot frame position tracker. It locks to the zero pulse and reports
// whether the first zero since reset has been seen.
module jt51_slot_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       zero,
    output logic [4:0] slot,
    output logic       synced
);
    logic [4:0] cnt_q;
    logic       synced_q;

    // The current slot is combinational, so the zero cycle itself is already slot 0.
    assign slot   = zero ? 5'd0 : cnt_q + 5'd1;
    assign synced = synced_q | zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 5'd0;
            synced_q <= 1'b0;
        end else if (cen) begin
            cnt_q    <= slot;
            synced_q <= synced;
        end
    end
endmodule

// File: rtl/jt51_eg_rd.sv
// jt51_eg_rd: reads back one slot of the time-multiplexed envelope stream. It also tracks
// the minimum attenuation of the read slot and a per-slot silence bitmap.
module jt51_eg_rd #(
    parameter logic [4:0] OFFSET    = 5'd0,
    parameter logic [9:0] SILENT_TH = 10'h3F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        zero,
    input  logic [9:0]  eg_XI,
    input  logic        rd_req,
    input  logic [4:0]  rd_slot,
    output logic        rd_busy,
    output logic        rd_ack,
    output logic [9:0]  rd_eg,
    input  logic        peak_clr,
    output logic [9:0]  peak_eg,
    output logic [31:0] silent,
    output logic        silent_all
);
    logic [4:0]  cur_slot, smp_slot, lat_q;
    logic        synced, hit, accept, cap;
    logic        busy_q, busy_d, ack_q, all_q;
    logic [9:0]  eg_q, peak_q, peak_d;
    logic [31:0] silent_q, silent_d;

    jt51_slot_cnt u_cnt (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .zero   (zero),
        .slot   (cur_slot),
        .synced (synced)
    );

    assign smp_slot = cur_slot + OFFSET;
    assign hit      = synced && smp_slot == lat_q;
    assign accept   = cen && rd_req && !busy_q;
    assign cap      = cen && busy_q && hit;
    assign busy_d   = accept || (busy_q && !cap);
    // Clear and a new request both restart the tracker, so they override the min-update.
    assign peak_d   = (peak_clr || accept) ? 10'h3FF : (hit && eg_XI < peak_q) ? eg_XI : peak_q;

    always_comb begin
        silent_d = silent_q;
        if (synced) silent_d[smp_slot] = eg_XI >= SILENT_TH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            eg_q     <= 10'h3FF;
            peak_q   <= 10'h3FF;
            lat_q    <= 5'd0;
            silent_q <= 32'hFFFF_FFFF;
            all_q    <= 1'b1;
        end else if (cen) begin
            busy_q   <= busy_d;
            ack_q    <= cap;
            eg_q     <= cap ? eg_XI : eg_q;
            lat_q    <= accept ? rd_slot : lat_q;
            peak_q   <= peak_d;
            silent_q <= silent_d;
            all_q    <= &silent_q;
        end
    end

    assign rd_busy    = busy_q;
    assign rd_ack     = ack_q;
    assign rd_eg      = eg_q;
    assign peak_eg    = peak_q;
    assign silent     = silent_q;
    assign silent_all = all_q;
endmodule
